// File: rtl/snn_step_sequencer_if.sv
// Control bundle between the timestep sequencer and its host / pipeline stages.
// The slave side is the sequencer; the master side drives start, abort and stage completions.
interface snn_step_sequencer_if #(
   parameter int NUM_STAGES = 11,
   parameter int NUM_STEPS  = 16
);
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int TW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

   logic                  start;
   logic                  abort;
   logic [NUM_STAGES-1:0] stage_done;
   logic [NUM_STAGES-1:0] stage_go;
   logic                  vmem_clear;
   logic                  vmem_latch;
   logic [SW-1:0]         cur_stage;
   logic [TW-1:0]         step_idx;
   logic                  busy;
   logic                  done;
   logic                  error;

   modport master (
      output start, abort, stage_done,
      input  stage_go, vmem_clear, vmem_latch, cur_stage, step_idx, busy, done, error
   );

   modport slave (
      input  start, abort, stage_done,
      output stage_go, vmem_clear, vmem_latch, cur_stage, step_idx, busy, done, error
   );
endinterface

// File: rtl/snn_step_sequencer.sv
// Central timestep FSM for the spiking-CNN pipeline: clears membranes, fires each stage's go
// in order, waits for its done, commits vmem per timestep and flags the prediction as valid.
module snn_step_sequencer #(
   parameter int NUM_STAGES  = 11,
   parameter int NUM_STEPS   = 16,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                i_clock,
   input  logic                i_reset,
   snn_step_sequencer_if.slave io_seq
);
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int TW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int WW = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_COMMIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t                r_state;
   logic [NUM_STAGES-1:0] r_stage_go;
   logic                  r_vmem_clear;
   logic                  r_vmem_latch;
   logic [SW-1:0]         r_cur_stage;
   logic [TW-1:0]         r_step_idx;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [WW-1:0]         r_wdog;

   logic [NUM_STAGES-1:0] w_done_hit;
   logic [NUM_STAGES-1:0] w_go_first;
   logic [NUM_STAGES-1:0] w_go_next;
   logic [SW-1:0]         w_cur_next;
   logic [WW-1:0]         w_wdog_inc;
   logic                  w_cur_hit;
   logic                  w_cur_last;
   logic                  w_step_last;
   logic                  w_wdog_exp;

   assign w_cur_next  = r_cur_stage + SW'(1);
   assign w_wdog_inc  = r_wdog + WW'(1);
   assign w_cur_last  = (r_cur_stage == SW'(NUM_STAGES - 1));
   assign w_step_last = (r_step_idx == TW'(NUM_STEPS - 1));
   assign w_wdog_exp  = (WDOG_CYCLES != 0) && (w_wdog_inc == WW'(WDOG_CYCLES));

   // Only the in-flight stage's completion counts; every other done bit is ignored.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         assign w_done_hit[gi] = io_seq.stage_done[gi] && (r_cur_stage == SW'(gi));
         assign w_go_first[gi] = (gi == 0) ? 1'b1 : 1'b0;
         assign w_go_next[gi]  = (w_cur_next == SW'(gi));
      end
   endgenerate

   assign w_cur_hit = |w_done_hit;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_stage_go   <= '0;
         r_vmem_clear <= 1'b0;
         r_vmem_latch <= 1'b0;
         r_cur_stage  <= '0;
         r_step_idx   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_wdog       <= '0;
      end else begin
         r_stage_go   <= '0;
         r_vmem_clear <= 1'b0;
         r_vmem_latch <= 1'b0;
         r_done       <= 1'b0;

         if (io_seq.abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_ERR: begin
                  // Outputs are registered, so each state's pulse is loaded on the edge entering it.
                  if (io_seq.start && !io_seq.abort) begin
                     r_state      <= S_CLEAR;
                     r_vmem_clear <= 1'b1;
                     r_step_idx   <= '0;
                     r_cur_stage  <= '0;
                     r_busy       <= 1'b1;
                     r_error      <= 1'b0;
                  end
               end
               S_CLEAR: begin
                  r_state    <= S_ISSUE;
                  r_stage_go <= w_go_first;
               end
               S_ISSUE: begin
                  r_state <= S_WAIT;
                  r_wdog  <= '0;
               end
               S_WAIT: begin
                  if (w_cur_hit) begin
                     if (!w_cur_last) begin
                        r_state     <= S_ISSUE;
                        r_cur_stage <= w_cur_next;
                        r_stage_go  <= w_go_next;
                     end else begin
                        r_state      <= S_COMMIT;
                        r_vmem_latch <= 1'b1;
                     end
                  end else if (w_wdog_exp) begin
                     r_state <= S_ERR;
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_wdog <= w_wdog_inc;
                  end
               end
               S_COMMIT: begin
                  if (w_step_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= S_ISSUE;
                     r_step_idx  <= r_step_idx + TW'(1);
                     r_cur_stage <= '0;
                     r_stage_go  <= w_go_first;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_seq.stage_go   = r_stage_go;
   assign io_seq.vmem_clear = r_vmem_clear;
   assign io_seq.vmem_latch = r_vmem_latch;
   assign io_seq.cur_stage  = r_cur_stage;
   assign io_seq.step_idx   = r_step_idx;
   assign io_seq.busy       = r_busy;
   assign io_seq.done       = r_done;
   assign io_seq.error      = r_error;
endmodule

// File: tb/tb_snn_step_sequencer.sv
// Bench for snn_step_sequencer: three configurations, a responder playing the pipeline stages,
// and a scoreboard of expected pulse events (code and cycle) checked as the DUT emits them.
module tb_snn_step_sequencer;
   typedef struct {
      int cyc;
      int code;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_r = 1'b0;
   logic        abort_r = 1'b0;
   logic [10:0] done_r = '0;
   int          sel = 0;

   always #5 clk = ~clk;

   snn_step_sequencer_if #(.NUM_STAGES(2),  .NUM_STEPS(2))  bus_a ();
   snn_step_sequencer_if #(.NUM_STAGES(11), .NUM_STEPS(16)) bus_b ();
   snn_step_sequencer_if #(.NUM_STAGES(2),  .NUM_STEPS(1))  bus_c ();

   snn_step_sequencer #(.NUM_STAGES(2), .NUM_STEPS(2), .WDOG_CYCLES(8)) u_a (
      .i_clock(clk), .i_reset(rst), .io_seq(bus_a));
   snn_step_sequencer #(.NUM_STAGES(11), .NUM_STEPS(16), .WDOG_CYCLES(65535)) u_b (
      .i_clock(clk), .i_reset(rst), .io_seq(bus_b));
   snn_step_sequencer #(.NUM_STAGES(2), .NUM_STEPS(1), .WDOG_CYCLES(0)) u_c (
      .i_clock(clk), .i_reset(rst), .io_seq(bus_c));

   assign bus_a.start      = start_r && (sel == 0);
   assign bus_a.abort      = abort_r && (sel == 0);
   assign bus_a.stage_done = (sel == 0) ? done_r[1:0] : 2'b00;
   assign bus_b.start      = start_r && (sel == 1);
   assign bus_b.abort      = abort_r && (sel == 1);
   assign bus_b.stage_done = (sel == 1) ? done_r : 11'd0;
   assign bus_c.start      = start_r && (sel == 2);
   assign bus_c.abort      = abort_r && (sel == 2);
   assign bus_c.stage_done = (sel == 2) ? done_r[1:0] : 2'b00;

   logic [10:0] obs_go;
   logic        obs_clear, obs_latch, obs_busy, obs_done, obs_error;
   int          obs_cur, obs_step;

   always_comb begin
      obs_go = '0; obs_clear = 1'b0; obs_latch = 1'b0; obs_busy = 1'b0;
      obs_done = 1'b0; obs_error = 1'b0; obs_cur = 0; obs_step = 0;
      case (sel)
         0: begin
            obs_go = 11'(bus_a.stage_go); obs_clear = bus_a.vmem_clear; obs_latch = bus_a.vmem_latch;
            obs_busy = bus_a.busy; obs_done = bus_a.done; obs_error = bus_a.error;
            obs_cur = int'(bus_a.cur_stage); obs_step = int'(bus_a.step_idx);
         end
         1: begin
            obs_go = bus_b.stage_go; obs_clear = bus_b.vmem_clear; obs_latch = bus_b.vmem_latch;
            obs_busy = bus_b.busy; obs_done = bus_b.done; obs_error = bus_b.error;
            obs_cur = int'(bus_b.cur_stage); obs_step = int'(bus_b.step_idx);
         end
         default: begin
            obs_go = 11'(bus_c.stage_go); obs_clear = bus_c.vmem_clear; obs_latch = bus_c.vmem_latch;
            obs_busy = bus_c.busy; obs_done = bus_c.done; obs_error = bus_c.error;
            obs_cur = int'(bus_c.cur_stage); obs_step = int'(bus_c.step_idx);
         end
      endcase
   end

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  resp_cnt = 0;
   int  resp_stage = 0;
   int  dly[11];
   ev_t exp_q[$];

   // One cycle step: sample on the falling edge and play the stages (dly < 0 = never answers).
   task automatic tick();
      @(negedge clk);
      cyc++;
      done_r = '0;
      if (obs_go != '0) begin
         for (int i = 0; i < 11; i++) if (obs_go[i]) resp_stage = i;
         resp_cnt = dly[resp_stage];
      end else if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) done_r[resp_stage] = 1'b1;
      end
   endtask

   // Event code: kind*10000 + step*100 + stage; 99999 flags a malformed go.
   function automatic int ev_code();
      int idx = -1;
      int n = 0;
      for (int i = 0; i < 11; i++) if (obs_go[i]) begin idx = i; n++; end
      if (n > 1 || (n == 1 && idx != obs_cur)) return 99999;
      if (n == 1) return 20000 + obs_step * 100 + idx;
      if (obs_clear) return 10000 + obs_step * 100 + obs_cur;
      if (obs_latch) return 30000 + obs_step * 100;
      if (obs_done) return 40000 + obs_step * 100;
      return 0;
   endfunction

   // Expected pulse schedule with every stage answering one cycle after its go.
   task automatic push_run(input int ns, input int nt, input bit timed);
      ev_t e;
      e.code = 10000; e.cyc = timed ? 1 : -1; exp_q.push_back(e);
      for (int t = 0; t < nt; t++) begin
         for (int s = 0; s < ns; s++) begin
            e.code = 20000 + t * 100 + s; e.cyc = timed ? 2 + t * (2 * ns + 1) + 2 * s : -1;
            exp_q.push_back(e);
         end
         e.code = 30000 + t * 100; e.cyc = timed ? 2 + t * (2 * ns + 1) + 2 * ns : -1;
         exp_q.push_back(e);
      end
      e.code = 40000 + (nt - 1) * 100; e.cyc = timed ? 2 + nt * (2 * ns + 1) : -1;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1; start_r = 1'b0; abort_r = 1'b0; done_r = '0;
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checks++; if (obs_go !== 11'd0) begin errors++; $display("FAIL reset_go dut=%0d got %h want 0", s, obs_go); end
         checks++; if ({obs_clear, obs_latch, obs_done} !== 3'b000) begin errors++; $display("FAIL reset_pulses dut=%0d got %b want 000", s, {obs_clear, obs_latch, obs_done}); end
         checks++; if (obs_cur !== 0) begin errors++; $display("FAIL reset_cur dut=%0d got %0d want 0", s, obs_cur); end
         checks++; if (obs_step !== 0) begin errors++; $display("FAIL reset_step dut=%0d got %0d want 0", s, obs_step); end
         checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy dut=%0d got %b want 0", s, obs_busy); end
         checks++; if (obs_error !== 1'b0) begin errors++; $display("FAIL reset_error dut=%0d got %b want 0", s, obs_error); end
      end
      rst = 1'b0; sel = 0;
      tick();
   endtask

   task automatic test_timing();
      ev_t e; int code;
      sel = 0; resp_cnt = 0; dly = '{default: 1}; exp_q.delete();
      push_run(2, 2, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 13; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL timing_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL timing_event got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         checks++; if (obs_busy !== (k <= 12)) begin errors++; $display("FAIL timing_busy @%0d got %b want %b", cyc, obs_busy, (k <= 12)); end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timing_missing got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_one_step();
      ev_t e; int code;
      sel = 2; resp_cnt = 0; dly = '{default: 1}; exp_q.delete();
      push_run(2, 1, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 8; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL one_step_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL one_step_event got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
      end
      checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL one_step_busy got %b want 0", obs_busy); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL one_step_missing got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_watchdog();
      ev_t e; int code;
      sel = 0; resp_cnt = 0; dly = '{default: 1}; dly[0] = -1; exp_q.delete();
      e.code = 10000; e.cyc = 1; exp_q.push_back(e);
      e.code = 20000; e.cyc = 2; exp_q.push_back(e);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 16; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL wdog_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL wdog_event got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         if (k == 10) begin
            checks++; if ({obs_error, obs_busy} !== 2'b01) begin errors++; $display("FAIL wdog_early err,busy got %b want 01", {obs_error, obs_busy}); end
         end
         if (k >= 11) begin
            checks++; if ({obs_error, obs_busy} !== 2'b10) begin errors++; $display("FAIL wdog_err @%0d err,busy got %b want 10", cyc, {obs_error, obs_busy}); end
         end
      end
      dly[0] = 1; resp_cnt = 0;
      push_run(2, 2, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 13; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL wdog_restart unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL wdog_restart got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         if (k == 1) begin
            checks++; if (obs_error !== 1'b0) begin errors++; $display("FAIL wdog_clear_err got %b want 0", obs_error); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wdog_missing got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      ev_t e; int code; int len5 = 0; int go_in5 = 0; bit seen = 0;
      sel = 1; resp_cnt = 0; dly = '{default: 1}; dly[5] = 100; exp_q.delete();
      push_run(11, 16, 1'b0);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 4000 && !seen; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stall_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code) begin errors++; $display("FAIL stall_event got %0d @%0d want %0d", code, cyc, e.code); end end
         end
         if (obs_busy && obs_cur == 5 && obs_step == 0) len5++;
         if (obs_go != '0 && obs_cur == 5) go_in5++;
         seen = obs_done;
      end
      checks++; if (!seen) begin errors++; $display("FAIL stall_timeout got no done want done within 4000 cycles"); end
      checks++; if (len5 != 101) begin errors++; $display("FAIL stall_hold got %0d cycles want 101", len5); end
      checks++; if (go_in5 != 16) begin errors++; $display("FAIL stall_go_count got %0d want 16", go_in5); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing got %0d pending want 0", exp_q.size()); end
      tick();
   endtask

   task automatic test_spurious();
      ev_t e; int code; bit seen = 0;
      sel = 1; resp_cnt = 0; dly = '{default: 1}; exp_q.delete();
      push_run(11, 16, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 600 && !seen; k++) begin
         tick();
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL spurious_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL spurious_event got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         if (obs_go != '0) done_r = done_r | obs_go;
         if (obs_busy && obs_cur == 2) done_r[7] = 1'b1;
         seen = obs_done;
         if (seen) start_r = 1'b0;
      end
      checks++; if (!seen) begin errors++; $display("FAIL spurious_timeout got no done want done"); end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (obs_busy !== 1'b0 || ev_code() != 0) begin errors++; $display("FAIL spurious_restart busy %b code %0d want 0 0", obs_busy, ev_code()); end
      end
      start_r = 1'b0;
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL spurious_missing got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_abort();
      ev_t e; int code; bit hit = 0; bit seen = 0;
      sel = 1; resp_cnt = 0; dly = '{default: 1}; exp_q.delete();
      push_run(11, 16, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 400 && !hit; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL abort_event unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL abort_event got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         hit = obs_busy && obs_step == 3 && obs_cur == 4;
      end
      checks++; if (!hit) begin errors++; $display("FAIL abort_reach got no step3/stage4 want reached"); end
      abort_r = 1'b1;
      tick(); abort_r = 1'b0;
      checks++; if ({obs_busy, obs_done, obs_error} !== 3'b000 || obs_go != '0) begin errors++; $display("FAIL abort_idle busy,done,err %b go %h want 000 0", {obs_busy, obs_done, obs_error}, obs_go); end
      exp_q.delete();
      for (int k = 0; k < 30; k++) begin
         tick();
         checks++; if (ev_code() != 0) begin errors++; $display("FAIL abort_quiet got code %0d want 0", ev_code()); end
      end
      resp_cnt = 0;
      push_run(11, 16, 1'b1);
      start_r = 1'b1; cyc = 0;
      for (int k = 1; k <= 600 && !seen; k++) begin
         tick(); start_r = 1'b0;
         code = ev_code();
         if (code != 0) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL abort_rerun unexpected code %0d @%0d", code, cyc); end
            else begin e = exp_q.pop_front(); if (code !== e.code || (e.cyc >= 0 && cyc !== e.cyc)) begin errors++; $display("FAIL abort_rerun got %0d @%0d want %0d @%0d", code, cyc, e.code, e.cyc); end end
         end
         seen = obs_done;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing got %0d pending want 0", exp_q.size()); end
      tick();
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      sel = 0; resp_cnt = 0; dly = '{default: 1}; dly[0] = -1;
      start_r = 1'b1; tick(); start_r = 1'b0;
      repeat (12) tick();
      checks++; if (obs_error !== 1'b1) begin errors++; $display("FAIL rstmid_pre_error got %b want 1", obs_error); end
      sel = 1; dly[0] = 1; resp_cnt = 0;
      start_r = 1'b1; tick(); start_r = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         tick();
         hit = obs_busy && obs_step == 1 && obs_cur == 3 && obs_go == '0;
      end
      checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got no WAIT step1/stage3 want reached"); end
      rst = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         sel = s; #1;
         checks++;
         if (obs_go != '0 || {obs_clear, obs_latch, obs_busy, obs_done, obs_error} !== 5'b0 || obs_cur != 0 || obs_step != 0) begin
            errors++;
            $display("FAIL rstmid_zero dut=%0d go %h flags %b cur %0d step %0d want all 0", s, obs_go,
                     {obs_clear, obs_latch, obs_busy, obs_done, obs_error}, obs_cur, obs_step);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      dly = '{default: 1};
      test_reset();
      test_timing();
      test_one_step();
      test_watchdog();
      test_stall();
      test_spurious();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
